user_bus_rr_arbiter: RTL and testbench

- Shares one downstream user bus (aw/w/b/ar/r channels) between C_NUM_PORTS upstream requesters, typically several Avalon-lite slave interface instances feeding one DMAC IO channel.
- Round-robin arbitration with one transaction in flight at a time.
- The grant is held until that transaction's response completes, so responses never need IDs.

---
 rtl/user_bus_rr_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_user_bus_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream user bus (aw/w/b/ar/r) between
// C_NUM_PORTS upstream requesters. One transaction is in flight at a time and
// the grant is held until its response completes, so no IDs are needed.
module user_bus_rr_arbiter #(
  parameter int unsigned C_NUM_PORTS  = 2,
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [C_NUM_PORTS-1:0]              s_awvalid,
  output logic [C_NUM_PORTS-1:0]              s_awready,
  input  logic [C_NUM_PORTS*C_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [C_NUM_PORTS*8-1:0]            s_awlen,
  input  logic [C_NUM_PORTS-1:0]              s_wvalid,
  output logic [C_NUM_PORTS-1:0]              s_wready,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_wdata,
  input  logic [C_NUM_PORTS-1:0]              s_wlast,
  output logic [C_NUM_PORTS-1:0]              s_bvalid,
  input  logic [C_NUM_PORTS-1:0]              s_bready,
  input  logic [C_NUM_PORTS-1:0]              s_arvalid,
  output logic [C_NUM_PORTS-1:0]              s_arready,
  input  logic [C_NUM_PORTS*C_ADDR_WIDTH-1:0] s_araddr,
  input  logic [C_NUM_PORTS*8-1:0]            s_arlen,
  output logic [C_DATA_WIDTH-1:0]             s_rdata,
  output logic                                s_rlast,
  output logic [C_NUM_PORTS-1:0]              s_rvalid,
  input  logic [C_NUM_PORTS-1:0]              s_rready,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  output logic [C_ADDR_WIDTH-1:0]             m_awaddr,
  output logic [7:0]                          m_awlen,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  output logic [C_DATA_WIDTH-1:0]             m_wdata,
  output logic                                m_wlast,
  input  logic                                m_bvalid,
  output logic                                m_bready,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [C_ADDR_WIDTH-1:0]             m_araddr,
  output logic [7:0]                          m_arlen,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [C_DATA_WIDTH-1:0]             m_rdata,
  input  logic                                m_rlast
);

  localparam int unsigned GW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic [7:0]             len_q, len_d;

  logic [C_NUM_PORTS-1:0] req, gmask;
  logic [GW-1:0]          next_grant;
  logic                   next_aw, found;
  logic                   g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic                   aw_acc, w_acc, w_fin;
  logic [8:0]             beat_nxt;

  assign req     = s_awvalid | s_arvalid;
  assign s_rdata = m_rdata;

  // Pick the first requesting port after last_grant, wrapping around.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant_q;
    next_aw    = 1'b0;
    for (int unsigned i = 1; i <= C_NUM_PORTS; i++) begin
      for (int unsigned j = 0; j < C_NUM_PORTS; j++) begin
        if (!found && req[j] && (j == (32'(last_grant_q) + i) % C_NUM_PORTS)) begin
          found      = 1'b1;
          next_grant = GW'(j);
          next_aw    = s_awvalid[j];
        end
      end
    end
  end

  // Combinational select of the granted port's controls and payload.
  always_comb begin
    gmask     = '0;
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wdata   = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    for (int unsigned j = 0; j < C_NUM_PORTS; j++) begin
      if (grant_q == GW'(j)) begin
        gmask[j]  = 1'b1;
        g_awvalid = s_awvalid[j];
        g_wvalid  = s_wvalid[j];
        g_bready  = s_bready[j];
        g_arvalid = s_arvalid[j];
        g_rready  = s_rready[j];
        m_awaddr  = s_awaddr[j*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        m_awlen   = s_awlen[j*8 +: 8];
        m_wdata   = s_wdata[j*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_araddr  = s_araddr[j*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        m_arlen   = s_arlen[j*8 +: 8];
      end
    end
  end

  // Next-state logic and handshake routing for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    m_wlast      = 1'b0;
    m_bready     = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s_awready    = '0;
    s_wready     = '0;
    s_bvalid     = '0;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rlast      = 1'b0;
    aw_acc       = 1'b0;
    w_acc        = 1'b0;
    w_fin        = 1'b0;
    beat_nxt     = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = next_grant;
          state_d = next_aw ? WADDR : RADDR;
        end
      end
      WADDR: begin
        m_awvalid = g_awvalid & ~aw_done_q;
        m_wvalid  = g_wvalid & ~w_done_q;
        s_awready = gmask & {C_NUM_PORTS{m_awready & ~aw_done_q}};
        s_wready  = gmask & {C_NUM_PORTS{m_wready & ~w_done_q}};
        aw_acc    = m_awvalid & m_awready;
        w_acc     = m_wvalid & m_wready;
        if (aw_done_q) m_wlast = (beat_cnt_q == {1'b0, len_q});
        else           m_wlast = aw_acc & (beat_cnt_q == {1'b0, m_awlen});
        beat_nxt = beat_cnt_q + 9'(w_acc);
        // Beats that slipped through before AW (length unknown, wlast low)
        // still complete the burst once AW arrives and shows they covered it.
        w_fin = (w_acc & m_wlast) | (aw_acc & (beat_nxt > {1'b0, m_awlen}));
        if (aw_acc) len_d = m_awlen;
        if ((aw_done_q | aw_acc) && (w_done_q | w_fin)) begin
          state_d    = WRESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          beat_cnt_d = '0;
        end else begin
          aw_done_d  = aw_done_q | aw_acc;
          w_done_d   = w_done_q | w_fin;
          beat_cnt_d = beat_nxt;
        end
      end
      WRESP: begin
        s_bvalid = gmask & {C_NUM_PORTS{m_bvalid}};
        m_bready = g_bready;
        if (m_bvalid && m_bready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      RADDR: begin
        m_arvalid = g_arvalid;
        s_arready = gmask & {C_NUM_PORTS{m_arready}};
        if (m_arvalid && m_arready) begin
          len_d      = m_arlen;
          beat_cnt_d = '0;
          state_d    = RDATA;
        end
      end
      RDATA: begin
        s_rvalid = gmask & {C_NUM_PORTS{m_rvalid}};
        s_rlast  = m_rlast;
        m_rready = g_rready;
        if (m_rvalid && m_rready) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (beat_cnt_q == {1'b0, len_q}) begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves port 0 with first priority.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(C_NUM_PORTS - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      beat_cnt_q   <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
    end
  end

endmodule

// File: tb/tb_user_bus_rr_arbiter.sv
// Directed self-checking bench for user_bus_rr_arbiter (2 ports, 32-bit).
module tb_user_bus_rr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [1:0]  s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_awaddr, s_wdata, s_araddr;
  logic [15:0] s_awlen, s_arlen;
  logic [31:0] s_rdata, m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        s_rlast;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready, m_rlast;
  logic [7:0]  m_awlen, m_arlen;

  int n_checks = 0;
  int n_fail   = 0;
  int aw_hs = 0, w_hs = 0, r_hs = 0;
  int aw_b, w_b, r_b;

  logic [16:0] all_ctl;
  assign all_ctl = {m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready,
                    s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast};

  user_bus_rr_arbiter #(.C_NUM_PORTS(2), .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast)
  );

  always #5 ACLK = ~ACLK;

  // Downstream handshake counters.
  always @(posedge ACLK) begin
    if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
    if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
    if (m_rvalid && m_rready)   r_hs  <= r_hs + 1;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    s_arvalid = '0; s_rready = '0; s_awaddr = '0; s_wdata = '0;
    s_araddr = '0; s_awlen = '0; s_arlen = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0;
    m_rvalid = 0; m_rlast = 0; m_rdata = 32'hCAFE0001;
    ARESET = 0;
    #1 ARESET = 1;
    #1 chk("reset_ctl", 64'(all_ctl), 0);
    tick();
    ARESET = 0;
    tick();

    // Single write, len 0, port 0
    s_awvalid = 2'b01; s_awaddr[31:0] = 32'h100; s_awlen[7:0] = 8'd0;
    s_wvalid = 2'b01; s_wdata[31:0] = 32'hDEADBEEF;
    m_awready = 1; m_wready = 1;
    #1 chk("wr_arb_cycle", 64'(m_awvalid), 0);
    tick();
    chk("wr_awvalid", 64'(m_awvalid), 1);
    chk("wr_wvalid", 64'(m_wvalid), 1);
    chk("wr_wlast", 64'(m_wlast), 1);
    chk("wr_awaddr", 64'(m_awaddr), 64'h100);
    chk("wr_wdata", 64'(m_wdata), 64'hDEADBEEF);
    chk("wr_s_awready", 64'(s_awready), 64'b01);
    chk("wr_s_wready", 64'(s_wready), 64'b01);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1;
    #1 chk("wr_bvalid", 64'(s_bvalid), 64'b01);
    chk("wr_bready_lo", 64'(m_bready), 0);
    s_bready = 2'b01;
    #1 chk("wr_bready_hi", 64'(m_bready), 1);
    tick();
    chk("wr_idle", 64'(s_bvalid), 0);
    m_bvalid = 0; s_bready = '0; m_awready = 0; m_wready = 0;

    // Alternating reads after a fresh reset
    ARESET = 1;
    #1 chk("reset2_ctl", 64'(all_ctl), 0);
    ARESET = 0;
    s_araddr = {32'h300, 32'h200}; s_arvalid = 2'b11;
    m_arready = 1; m_rvalid = 1; m_rlast = 1; s_rready = 2'b11;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_idle", 64'(m_arvalid), 0);
      tick();
      chk("rr_arvalid", 64'(m_arvalid), 1);
      chk("rr_araddr", 64'(m_araddr), (k % 2 == 1) ? 64'h300 : 64'h200);
      chk("rr_arready", 64'(s_arready), (k % 2 == 1) ? 64'b10 : 64'b01);
      chk("rr_no_rvalid", 64'(s_rvalid), 0);
      tick();
      chk("rr_rvalid", 64'(s_rvalid), (k % 2 == 1) ? 64'b10 : 64'b01);
      chk("rr_rdata", 64'(s_rdata), 64'hCAFE0001);
      tick();
    end
    s_arvalid = '0; m_rvalid = 0; s_rready = '0; m_arready = 0; m_rlast = 0;

    // W before AW, port 0 (port 1 served last)
    aw_b = aw_hs; w_b = w_hs;
    s_awvalid = 2'b01; s_awaddr[31:0] = 32'h140; s_awlen[7:0] = 8'd0;
    s_wvalid = 2'b01; s_wdata[31:0] = 32'h11111111;
    m_awready = 0; m_wready = 1;
    tick();
    chk("wf_wvalid", 64'(m_wvalid), 1);
    chk("wf_wlast", 64'(m_wlast), 0);
    chk("wf_awready", 64'(s_awready), 0);
    tick();
    s_wvalid = '0;
    #1 chk("wf_aw_wait", 64'(m_awvalid), 1);
    tick();
    tick();
    m_awready = 1;
    #1 chk("wf_s_awready", 64'(s_awready), 64'b01);
    tick();
    s_awvalid = '0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; s_bready = 2'b01;
    #1 chk("wf_bvalid", 64'(s_bvalid), 64'b01);
    chk("wf_aw_count", 64'(aw_hs - aw_b), 1);
    chk("wf_w_count", 64'(w_hs - w_b), 1);
    tick();
    m_bvalid = 0; s_bready = '0;

    // AW before W, port 1, two beats; awvalid held high to probe the AW guard
    aw_b = aw_hs; w_b = w_hs;
    s_awvalid = 2'b10; s_awaddr[63:32] = 32'h180; s_awlen[15:8] = 8'd1;
    s_wvalid = 2'b10; s_wdata[63:32] = 32'hA0A0A0A0;
    m_awready = 1; m_wready = 0;
    tick();
    chk("af_awaddr", 64'(m_awaddr), 64'h180);
    chk("af_awlen", 64'(m_awlen), 1);
    chk("af_wlast", 64'(m_wlast), 0);
    chk("af_s_awready", 64'(s_awready), 64'b10);
    tick();
    chk("af_no_dup_aw", 64'(m_awvalid), 0);
    chk("af_w_stall", 64'(s_wready), 0);
    tick();
    tick();
    m_wready = 1;
    #1 chk("af_beat0_last", 64'(m_wlast), 0);
    chk("af_s_wready", 64'(s_wready), 64'b10);
    tick();
    s_wdata[63:32] = 32'hB0B0B0B0;
    #1 chk("af_beat1_last", 64'(m_wlast), 1);
    chk("af_beat1_data", 64'(m_wdata), 64'hB0B0B0B0);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; s_bready = 2'b10;
    #1 chk("af_bvalid", 64'(s_bvalid), 64'b10);
    chk("af_aw_count", 64'(aw_hs - aw_b), 1);
    chk("af_w_count", 64'(w_hs - w_b), 2);
    tick();
    m_bvalid = 0; s_bready = '0;

    // Read of 4 beats with m_rlast stuck low, with an s_rready stall
    r_b = r_hs;
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h400; s_arlen[7:0] = 8'd3;
    m_arready = 1; m_rvalid = 1; m_rlast = 0; s_rready = 2'b01;
    tick();
    tick();
    s_arvalid = '0;
    #1 chk("r4_rvalid", 64'(s_rvalid), 64'b01);
    tick();
    s_rready = '0;
    #1 chk("r4_stall", 64'(m_rready), 0);
    tick();
    tick();
    s_rready = 2'b01;
    #1 chk("r4_resume", 64'(m_rready), 1);
    tick();
    tick();
    tick();
    chk("r4_idle", 64'(s_rvalid), 0);
    chk("r4_beats", 64'(r_hs - r_b), 4);
    m_rvalid = 0; s_rready = '0; m_arready = 0;

    // Port 1 asserts both: write first, read next
    s_awvalid = 2'b10; s_arvalid = 2'b10; s_wvalid = 2'b10;
    s_awaddr[63:32] = 32'h500; s_awlen[15:8] = 8'd0;
    s_araddr[63:32] = 32'h600; s_arlen[15:8] = 8'd0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    tick();
    chk("both_awvalid", 64'(m_awvalid), 1);
    chk("both_no_ar", 64'(m_arvalid), 0);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1; s_bready = 2'b10;
    #1 chk("both_bready", 64'(m_bready), 1);
    tick();
    m_bvalid = 0; s_bready = '0;
    #1 chk("both_idle", 64'(m_arvalid), 0);
    tick();
    chk("both_arvalid", 64'(m_arvalid), 1);
    chk("both_araddr", 64'(m_araddr), 64'h600);
    chk("both_arready", 64'(s_arready), 64'b10);
    tick();
    s_arvalid = '0; m_rvalid = 1; s_rready = 2'b10;
    #1 chk("both_rvalid", 64'(s_rvalid), 64'b10);
    tick();
    m_rvalid = 0; s_rready = '0; m_awready = 0; m_wready = 0;

    // Make port 0 the most recent winner, then abort a port-1 read mid-burst
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h200; s_arlen[7:0] = 8'd0;
    m_rvalid = 1; s_rready = 2'b01;
    tick();
    tick();
    s_arvalid = '0;
    tick();
    m_rvalid = 0; s_rready = '0;
    s_arvalid = 2'b10; s_araddr[63:32] = 32'h700; s_arlen[15:8] = 8'd3;
    tick();
    tick();
    s_arvalid = '0; m_rvalid = 1; s_rready = 2'b10;
    tick();
    tick();
    chk("rst_pre", 64'(s_rvalid), 64'b10);
    ARESET = 1;
    #1 chk("rst_abort", 64'(all_ctl), 0);
    ARESET = 0; m_rvalid = 0; s_rready = '0;
    s_araddr = {32'h300, 32'h200}; s_arlen = '0; s_arvalid = 2'b11;
    #1 chk("rst_idle", 64'(m_arvalid), 0);
    tick();
    chk("rst_prio_ready", 64'(s_arready), 64'b01);
    chk("rst_prio_addr", 64'(m_araddr), 64'h200);
    tick();
    s_arvalid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
